// File: rtl/pll_rst_pkg.sv
// -----------------------------------------------------------------------------
// pll_rst_pkg
// Shared definitions for the PLL reset controller: FSM state encoding,
// default parameter constants and a small state decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package pll_rst_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } pll_state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4096;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_LOSS_CNT_W    = 8;

    // Downstream reset is released only while the controller is in RUN.
    function automatic logic is_run(input pll_state_e s);
        return (s == RUN);
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// -----------------------------------------------------------------------------
// pll_reset_ctrl_if
// Groups the PLL-side and reset-side signals of pll_reset_ctrl.
//   locked     : PLL lock indicator, asynchronous to the controller clock
//   rst_out_n  : registered active-low reset for downstream logic
//   ready      : registered status, same timing as rst_out_n
//   loss_count : saturating count of RUN-to-lock-loss events
// Signalling: there is no valid/ready handshake on this interface. "ready" is
// a level status flag (high exactly while the controller is in RUN); nothing
// is transferred on it and no acknowledge is expected from the consumer.
// Modports:
//   master : environment side (drives locked, observes the outputs)
//   slave  : controller side
// -----------------------------------------------------------------------------
interface pll_reset_ctrl_if #(
    parameter int LOSS_CNT_W = 8
);
    logic                  locked;
    logic                  rst_out_n;
    logic                  ready;
    logic [LOSS_CNT_W-1:0] loss_count;

    modport master (
        output locked,
        input  rst_out_n,
        input  ready,
        input  loss_count
    );

    modport slave (
        input  locked,
        output rst_out_n,
        output ready,
        output loss_count
    );
endinterface

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Generic multi-flop synchronizer for a single-bit asynchronous signal.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low clear (all stages go to 0)
//   d     : asynchronous input
//   q     : synchronized output (last stage)
// Parameter DEPTH: number of flops in the chain (2 or more).
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    // Stage 0 captures the raw input; each later stage copies its predecessor.
    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// pll_reset_ctrl
// Holds downstream logic in reset until the PLL has reported lock for
// STABLE_CYCLES consecutive synchronized cycles, and re-asserts reset for at
// least HOLD_CYCLES cycles whenever lock is lost while running.
// Ports:
//   clock_in  : PLL output clock, all state on the rising edge
//   reset_n   : asynchronous active-low reset
//   bus       : pll_reset_ctrl_if.slave (locked in; rst_out_n, ready,
//               loss_count out)
//   state_dbg : current FSM state (WAIT_LOCK=0, STABILIZE=1, RUN=2, HOLD=3)
// Build option: define PLL_RST_LOSS_COUNTER_EN to include the saturating
// lock-loss counter; otherwise loss_count is tied to 0.
// -----------------------------------------------------------------------------
module pll_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int LOSS_CNT_W    = DEF_LOSS_CNT_W
) (
    input  logic               clock_in,
    input  logic               reset_n,
    pll_reset_ctrl_if.slave    bus,
    output logic [STATE_W-1:0] state_dbg
);

    // Counters are sized to hold their terminal value without wrapping.
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic              locked_s;
    pll_state_e        state_q,    state_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              rst_out_n_q, rst_out_n_d;
    logic              ready_q,     ready_d;

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clock_in),
        .rst_n (reset_n),
        .d     (bus.locked),
        .q     (locked_s)
    );

    // State register (plus counters and registered outputs).
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_LOCK;
            stab_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            rst_out_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rst_out_n_q <= rst_out_n_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d    = STABILIZE;
                    stab_cnt_d = '0;
                end
            end
            STABILIZE: begin
                // Any low sample, however short, restarts qualification.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d = RUN;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            HOLD: begin
                // locked_s is deliberately ignored until the hold time expires.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // Output logic: decoded from the next state so the registered outputs
    // change on the same edge as the state register.
    always_comb begin
        rst_out_n_d = is_run(state_d);
        ready_d     = is_run(state_d);
    end

    assign bus.rst_out_n = rst_out_n_q;
    assign bus.ready     = ready_q;
    assign state_dbg     = state_q;

`ifdef PLL_RST_LOSS_COUNTER_EN
    logic                  loss_evt;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    assign loss_evt = (state_q == RUN) && (state_d == HOLD);

    // Saturating: holds at all-ones instead of wrapping.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_evt && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign bus.loss_count = loss_cnt_q;
`else
    assign bus.loss_count = '0;
`endif

endmodule

// File: doc/pll_reset_ctrl.md
PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops in the locked synchronizer (legal 2..4).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4096, number of consecutive synchronized-locked cycles required before reset release (legal >= 1).
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, minimum cycles rst_out_n stays low after a lock loss (legal >= 1).
REQ-004 SHALL have parameter LOSS_CNT_W, default 8, width of the lock-loss counter.
REQ-005 SHALL have port clock_in, input, 1, the single clock (PLL output domain); all state is clocked on the rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port locked, input, 1, PLL lock indicator, asynchronous to clock_in.
REQ-008 SHALL have port rst_out_n, output, 1, registered active-low reset for downstream logic.
REQ-009 SHALL have port ready, output, 1, high exactly when the FSM is in RUN (registered, identical timing to rst_out_n).
REQ-010 SHALL have port loss_count, output, LOSS_CNT_W, number of RUN-to-lock-loss events seen since reset.

Function
REQ-011 SHALL synchronize locked through a SYNC_STAGES-flop chain into locked_s; no other logic SHALL sample locked directly.
REQ-012 SHALL implement FSM states WAIT_LOCK, STABILIZE, RUN, HOLD.
REQ-013 WAIT_LOCK: when locked_s=1, SHALL go to STABILIZE with the stable counter cleared to 0; otherwise SHALL stay.
REQ-014 STABILIZE: when locked_s=0, SHALL return to WAIT_LOCK; when locked_s=1 and the counter equals STABLE_CYCLES-1, SHALL go to RUN; otherwise SHALL increment the counter.
REQ-015 RUN: when locked_s=0, SHALL go to HOLD with the hold counter cleared and SHALL increment loss_count; otherwise SHALL stay.
REQ-016 HOLD: SHALL ignore locked_s and go to WAIT_LOCK after exactly HOLD_CYCLES cycles in HOLD.
REQ-017 rst_out_n and ready SHALL be registered and SHALL be 1 iff the registered state is RUN.
REQ-018 Release latency: rst_out_n SHALL rise on edge SYNC_STAGES+STABLE_CYCLES+1, counting the first edge that samples locked=1 as edge 1, provided locked stays high.
REQ-019 Loss latency: rst_out_n SHALL fall on edge SYNC_STAGES+1 after the first edge that samples locked=0 in RUN.
REQ-020 loss_count SHALL saturate at 2^LOSS_CNT_W-1 and SHALL never wrap.
REQ-021 The stable counter SHALL be sized clog2(STABLE_CYCLES+1) bits; the hold counter SHALL be sized clog2(HOLD_CYCLES+1) bits; no counter SHALL wrap.
REQ-022 A locked_s low pulse of any length during STABILIZE SHALL restart qualification from WAIT_LOCK.

Reset
REQ-023 reset_n=0 SHALL asynchronously force state=WAIT_LOCK, all counters=0, synchronizer flops=0, rst_out_n=0, ready=0, loss_count=0.
REQ-024 Reset assertion mid-STABILIZE or mid-HOLD SHALL discard all progress; after deassertion, behaviour SHALL be as from power-up.

Configuration
REQ-025 With macro PLL_RST_LOSS_COUNTER_EN defined, loss_count SHALL behave per REQ-015/REQ-020.
REQ-026 Without PLL_RST_LOSS_COUNTER_EN, loss_count SHALL be tied to 0, no counter register SHALL be synthesized, and all other behaviour SHALL be unchanged.

Structure
REQ-027 The FSM state encoding (2-bit, WAIT_LOCK=0, STABILIZE=1, RUN=2, HOLD=3) and default parameter constants SHALL live in shared package pll_rst_pkg.
REQ-028 The synchronizer SHALL be a separate sub-module sync_ff (parameterized depth, async active-low clear), reusable elsewhere.

Verification (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, LOSS_CNT_W=2)
REQ-029 Release bench: reset released, locked=1 sampled at edge 1 -> rst_out_n and ready rise at edge 11, not before.
REQ-030 Qualification-glitch bench: locked drops for 3 cycles while in STABILIZE -> FSM returns to WAIT_LOCK; release occurs 11 edges after lock is re-sampled high.
REQ-031 Loss bench: locked falls in RUN -> rst_out_n falls on edge 3; rst_out_n stays low at least 4 cycles even if locked returns immediately; loss_count=1.
REQ-032 Saturation bench: 5 RUN-to-loss events -> loss_count reads 1,2,3,3,3.
REQ-033 Async reset bench: reset_n pulsed low between clock edges while in RUN -> rst_out_n=0, ready=0, loss_count=0 before the next edge.
REQ-034 Macro-off bench: PLL_RST_LOSS_COUNTER_EN undefined, repeat REQ-031 -> loss_count stays 0; rst_out_n timing is identical.
